mips_multicycle_ctrl: RTL

//  Multicycle MIPS control FSM; drives the datapath select/enable strobes and the 4-bit ALU operation code.

---
 rtl/mips_multicycle_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Multicycle MIPS control FSM, datapath strobes and ALU op code
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int BIT_SEL = 3,
  parameter int OP_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Opcode,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [BIT_SEL:0]   ALUControl,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  localparam int ALU_W = BIT_SEL + 1;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB    = 4'd7,
    IEXEC  = 4'd8,  IWB    = 4'd9,  BRANCH = 4'd10, JUMP   = 4'd11
  } state_t;

  state_t     state;
  logic       is_mem, is_imm, funct_ok;
  logic [3:0] funct_alu, imm_alu, alu_code;

  always_comb begin
    is_mem = (Opcode == OP_LW) || (Opcode == OP_SW);
    is_imm = 1'b1;
    imm_alu = 4'd0;
    case (Opcode)
      OP_ADDI: imm_alu = 4'd0;
      OP_ANDI: imm_alu = 4'd1;
      OP_ORI:  imm_alu = 4'd3;
      OP_SLTI: imm_alu = 4'd4;
      OP_LUI:  imm_alu = 4'd14;
      default: is_imm  = 1'b0;
    endcase
    funct_ok  = 1'b1;
    funct_alu = 4'd0;
    case (Funct)
      6'b100000: funct_alu = 4'd0;
      6'b100100: funct_alu = 4'd1;
      6'b100111: funct_alu = 4'd2;
      6'b100101: funct_alu = 4'd3;
      6'b101010: funct_alu = 4'd4;
      FN_SLL:    funct_alu = 4'd5;
      FN_SRL:    funct_alu = 4'd6;
      6'b100010: funct_alu = 4'd7;
      6'b011000: funct_alu = 4'd9;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          if (is_mem)                                      state <= MEMADR;
          else if (Opcode == OP_R)                         state <= REXEC;
          else if (Opcode == OP_BEQ || Opcode == OP_BNE)   state <= BRANCH;
          else if (is_imm)                                 state <= IEXEC;
          else if (Opcode == OP_J)                         state <= JUMP;
          else                                             state <= FETCH;
        end
        MEMADR: state <= (Opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  state <= MEMWB;
        REXEC:  state <= funct_ok ? RWB : FETCH;
        IEXEC:  state <= IWB;
        default: state <= FETCH;  // also recovers encodings 12-15
      endcase
    end
  end

  // Outputs are forced low while reset is held, even though state already reads FETCH.
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    alu_code   = 4'd0;
    PCSrc      = 2'd0;
    PCWrite    = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = 2'd1;
          PCWrite = 1'b1;
        end
        DECODE: begin
          ALUSrcB    = 2'd3;
          illegal_op = !(is_mem || is_imm || Opcode == OP_R || Opcode == OP_J ||
                         Opcode == OP_BEQ || Opcode == OP_BNE);
        end
        MEMADR: begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
        end
        MEMRD:  IorD = 1'b1;
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        REXEC: begin
          ALUSrcA    = (Funct == FN_SLL || Funct == FN_SRL) ? 2'd2 : 2'd1;
          alu_code   = funct_alu;
          illegal_op = !funct_ok;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        IEXEC: begin
          ALUSrcA  = 2'd1;
          ALUSrcB  = 2'd2;
          alu_code = imm_alu;
        end
        IWB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA  = 2'd1;
          alu_code = (Opcode == OP_BEQ) ? 4'd10 : 4'd11;
          PCSrc    = 2'd1;
          PCWrite  = Zero;
        end
        JUMP: begin
          PCSrc   = 2'd2;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUControl = ALU_W'(alu_code);
  assign state_o    = state;

endmodule
`default_nettype wire
